// File: rtl/hub75_blanking_pkg.sv
// hub75_blanking_pkg: shared types for the HUB75 blanking generator.
// Holds the per-run configuration snapshot taken when a go is accepted.
package hub75_blanking_pkg;

   localparam int CFG_W = 8;

   // Configuration captured at go; later port changes do not reach the run.
   typedef struct packed {
      logic [CFG_W-1:0] bcm_bit_len;  // tick length minus one, in clocks
      logic [CFG_W-1:0] on_len;       // display-on clocks at the start of each tick
      logic [CFG_W-1:0] guard_len;    // guard clocks minus one
   } cfg_t;

endpackage : hub75_blanking_pkg

// File: rtl/hub75_blanking.sv
// hub75_blanking: drives the HUB75 panel blank line for one bit-plane.
// A go with a one-hot plane k keeps the display lit for 2^k ticks of
// (bcm_bit_len+1) clocks, dimmed within each tick to on_len clocks, then
// holds blank for a guard period before reporting ready again.
module hub75_blanking
   import hub75_blanking_pkg::*;
#(
   parameter int N_PLANES = 8
) (
   input  logic                clk,
   input  logic                rst,
   output logic                phy_blank,
   input  logic [N_PLANES-1:0] ctrl_plane,
   input  logic                ctrl_go,
   output logic                ctrl_rdy,
   input  logic [CFG_W-1:0]    cfg_bcm_bit_len,
   input  logic [CFG_W-1:0]    cfg_on_len,
   input  logic [CFG_W-1:0]    cfg_guard_len
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ON    = 2'd1;
   localparam logic [1:0] ST_GUARD = 2'd2;

   localparam logic [N_PLANES-1:0] TICK_LAST = N_PLANES'(1);

   logic [1:0]          state_q;
   logic [1:0]          state_d;
   logic [N_PLANES-1:0] tick_q;     // remaining ticks; starts at the one-hot plane value
   logic [CFG_W-1:0]    pre_q;      // clock position within the current tick
   logic [CFG_W-1:0]    guard_q;    // remaining guard clocks minus one
   cfg_t                cfg_q;
   logic                tick_end;
   logic                last_tick;
   logic                blank_d;

   assign tick_end  = (pre_q == cfg_q.bcm_bit_len);
   // The exit test fires while one tick remains, so the counter never wraps.
   assign last_tick = (tick_q == TICK_LAST);

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours, independent of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode.
   // NOTE: state_d gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (ctrl_go)              state_d = ST_ON;
         ST_ON:    if (tick_end && last_tick) state_d = ST_GUARD;
         ST_GUARD: if (guard_q == '0)        state_d = ST_IDLE;
         default:                            state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from state: ready in IDLE, lit while inside the on-window.
   always_comb begin
      ctrl_rdy = (state_q == ST_IDLE);
      blank_d  = !((state_q == ST_ON) && (pre_q < cfg_q.on_len));
   end

   // Datapath: config capture, prescaler, tick and guard counters, blank register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_q    <= '0;
         pre_q     <= '0;
         guard_q   <= '0;
         cfg_q     <= '0;
         phy_blank <= 1'b1;
      end else begin
         phy_blank <= blank_d;
         case (state_q)
            ST_IDLE: begin
               if (ctrl_go) begin
                  tick_q            <= ctrl_plane;
                  cfg_q.bcm_bit_len <= cfg_bcm_bit_len;
                  cfg_q.on_len      <= cfg_on_len;
                  cfg_q.guard_len   <= cfg_guard_len;
                  pre_q             <= '0;
               end
            end
            ST_ON: begin
               if (tick_end) begin
                  pre_q  <= '0;
                  tick_q <= tick_q - TICK_LAST;
                  if (last_tick) begin
                     guard_q <= cfg_q.guard_len;
                  end
               end else begin
                  pre_q <= pre_q + 1'b1;
               end
            end
            ST_GUARD: begin
               if (guard_q != '0) begin
                  guard_q <= guard_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule : hub75_blanking

// File: tb/tb_hub75_blanking.sv
// tb_hub75_blanking: directed runs with hand-computed expectations pushed
// into a scoreboard queue; a monitor measures each completed run (from the
// accepted go until ctrl_rdy returns) and compares it with the queue head.
module tb_hub75_blanking;

   localparam int N_PLANES = 8;
   localparam int RUN_LIMIT = 3000;

   typedef struct {
      int first_low;  // cycle of first blank low, -1 if none
      int low_cnt;    // total low cycles
      int pulses;     // number of low runs
      int max_run;    // longest low run
      int rdy_cyc;    // cycle ctrl_rdy returns
   } exp_t;

   logic                clk;
   logic                rst;
   logic                phy_blank;
   logic [N_PLANES-1:0] ctrl_plane;
   logic                ctrl_go;
   logic                ctrl_rdy;
   logic [7:0]          cfg_bcm_bit_len;
   logic [7:0]          cfg_on_len;
   logic [7:0]          cfg_guard_len;

   int   n_cmp;
   int   n_bad;
   exp_t exp_q[$];

   hub75_blanking #(.N_PLANES(N_PLANES)) dut (
      .clk             (clk),
      .rst             (rst),
      .phy_blank       (phy_blank),
      .ctrl_plane      (ctrl_plane),
      .ctrl_go         (ctrl_go),
      .ctrl_rdy        (ctrl_rdy),
      .cfg_bcm_bit_len (cfg_bcm_bit_len),
      .cfg_on_len      (cfg_on_len),
      .cfg_guard_len   (cfg_guard_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: samples on the falling edge, measures each run, pops and compares.
   initial begin
      bit active;
      int cyc, low, pulses, run, max_run, first_low;
      bit prev_blank;
      active = 0;
      cyc = 0; low = 0; pulses = 0; run = 0; max_run = 0; first_low = -1;
      prev_blank = 1;
      forever begin
         @(negedge clk);
         if (rst) begin
            active = 0;
         end else begin
            if (active) begin
               cyc++;
               if (ctrl_rdy) begin
                  exp_t e;
                  active = 0;
                  check("blank_at_rdy", int'(phy_blank), 1);
                  if (exp_q.size() == 0) begin
                     check("unexpected_run", 1, 0);
                  end else begin
                     e = exp_q.pop_front();
                     check("first_low", first_low, e.first_low);
                     check("low_cnt",   low,       e.low_cnt);
                     check("pulses",    pulses,    e.pulses);
                     check("max_run",   max_run,   e.max_run);
                     check("rdy_cyc",   cyc,       e.rdy_cyc);
                  end
               end else begin
                  if (!phy_blank) begin
                     low++;
                     run++;
                     if (prev_blank) begin
                        pulses++;
                        if (first_low < 0) first_low = cyc;
                     end
                     if (run > max_run) max_run = run;
                  end else begin
                     run = 0;
                  end
                  prev_blank = phy_blank;
                  if (cyc > RUN_LIMIT) begin
                     check("run_timeout", cyc, RUN_LIMIT);
                     active = 0;
                  end
               end
            end
            // A go seen while ready starts a new run (also in the completing cycle).
            if (!active && ctrl_go && ctrl_rdy) begin
               active = 1;
               cyc = 0; low = 0; pulses = 0; run = 0; max_run = 0; first_low = -1;
               prev_blank = 1;
            end
         end
      end
   end

   // Stimulus helpers: called at posedge+1.
   task automatic wait_rdy();
      int n;
      n = 0;
      while (!ctrl_rdy && n < RUN_LIMIT) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ctrl_rdy) check("wait_rdy_timeout", 0, 1);
   endtask

   task automatic run(input logic [7:0] plane, input logic [7:0] l,
                      input logic [7:0] on, input logic [7:0] g,
                      input bit push, input exp_t e);
      wait_rdy();
      ctrl_plane      = plane;
      cfg_bcm_bit_len = l;
      cfg_on_len      = on;
      cfg_guard_len   = g;
      ctrl_go         = 1'b1;
      if (push) exp_q.push_back(e);
      @(posedge clk); #1;
      ctrl_go = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      ctrl_go = 1'b0;
      ctrl_plane = 8'h01;
      cfg_bcm_bit_len = 8'd0;
      cfg_on_len = 8'd0;
      cfg_guard_len = 8'd0;
      #3;
      check("reset_blank", int'(phy_blank), 1);
      check("reset_rdy",   int'(ctrl_rdy),  1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // plane 1, L=3, on=4, G=0: low 2..5, ready at 6.
      run(8'h01, 8'd3, 8'd4, 8'd0, 1, '{2, 4, 1, 4, 6});
      // plane 128, L=0, on=1, G=2: 128 low clocks, ready at 132 (back-to-back go).
      run(8'h80, 8'd0, 8'd1, 8'd2, 1, '{2, 128, 1, 128, 132});
      // plane 4, L=7, on=2, G=0: four 2-clock pulses, ready at 34.
      run(8'h04, 8'd7, 8'd2, 8'd0, 1, '{2, 8, 4, 2, 34});
      // on=0, plane 2, L=1: never lit, ready at 6.
      run(8'h02, 8'd1, 8'd0, 8'd0, 1, '{-1, 0, 0, 0, 6});
      // plane 2, L=3, on=2, G=1: low 2,3,6,7, ready at 11; disturbed mid-run.
      run(8'h02, 8'd3, 8'd2, 8'd1, 1, '{2, 4, 2, 2, 11});
      ctrl_go = 1'b1;
      cfg_on_len = 8'hFF;
      cfg_bcm_bit_len = 8'd0;
      cfg_guard_len = 8'd50;
      ctrl_plane = 8'h80;
      @(posedge clk); #1;
      ctrl_go = 1'b0;
      @(posedge clk); #1;
      ctrl_go = 1'b1;
      @(posedge clk); #1;
      ctrl_go = 1'b0;
      // on > L: plane 1, L=2, on=9, G=3: low 2..4, ready at 8.
      run(8'h01, 8'd2, 8'd9, 8'd3, 1, '{2, 3, 1, 3, 8});

      // Reset mid-ST_ON: aborted run has no expectation.
      run(8'h10, 8'd3, 8'd4, 8'd0, 0, '{0, 0, 0, 0, 0});
      repeat (4) begin
         @(posedge clk); #1;
      end
      check("mid_on_blank_low", int'(phy_blank), 0);
      #1;
      rst = 1'b1;
      #1;
      check("rst_async_blank", int'(phy_blank), 1);
      check("rst_async_rdy",   int'(ctrl_rdy),  1);
      @(posedge clk); #1;
      rst = 1'b0;
      check("post_rst_rdy",   int'(ctrl_rdy),  1);
      check("post_rst_blank", int'(phy_blank), 1);
      @(posedge clk); #1;
      run(8'h01, 8'd3, 8'd4, 8'd0, 1, '{2, 4, 1, 4, 6});

      wait_rdy();
      begin
         int n;
         n = 0;
         while (exp_q.size() != 0 && n < RUN_LIMIT) begin
            @(posedge clk); #1;
            n++;
         end
      end
      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_hub75_blanking
